// File: rtl/spi_flash_reader.sv
// spi_flash_reader: serial-flash READ sequencer in front of an 8-bit spi_master.
// Sends CMD + 24-bit address, then LEN dummy bytes to clock data back, and
// forwards the LEN received bytes as a one-cycle-strobe byte stream. A fixed
// GAP of idle cycles after each transaction lets the master drop cs_n.
module spi_flash_reader #(
  parameter int          LW  = 16,
  parameter logic [7:0]  CMD = 8'h03,
  parameter int          GAP = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [23:0]   addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [7:0]    spm_in,
  input  logic          spm_get,
  output logic          spm_empty,
  input  logic [7:0]    spm_out,
  input  logic          spm_put
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  // Header bytes on the wire ahead of the dummy/data phase: CMD + 3 address.
  localparam logic [LW:0] HDR = (LW+1)'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DRAIN, S_GAP
  } state_t;

  // Request captured at acceptance; held for the whole transaction.
  typedef struct packed {
    logic [23:0]   addr;
    logic [LW-1:0] len;
  } rd_req_t;

  state_t      state;
  rd_req_t     cur;
  logic [LW:0] tx_cnt;
  logic [LW:0] rx_cnt;
  logic [1:0]  addr_idx;
  logic [GW-1:0] gap_cnt;

  logic        tx_take;
  logic        rx_take;
  logic [LW:0] tx_nxt;
  logic [LW:0] rx_end;

  // A get only counts while a byte is actually offered; puts are tracked
  // for the whole transaction so the header echo can be discarded.
  assign tx_take = spm_get & ~spm_empty;
  assign rx_take = spm_put & (state != S_IDLE);
  assign tx_nxt  = tx_cnt + (LW+1)'(1);
  assign rx_end  = {1'b0, cur.len} + HDR;

  // Sequencer FSM with registered outputs; RX counting lives here too so the
  // counter clear on acceptance and the put accounting cannot race.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      addr_idx  <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      spm_in    <= '0;
      spm_empty <= 1'b1;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;

      // Receive side: puts 1..4 are the header echo, puts 5..len+4 are data,
      // anything after that is dropped. Saturate rather than wrap.
      if (rx_take) begin
        if (rx_cnt != '1)
          rx_cnt <= rx_cnt + (LW+1)'(1);
        if (rx_cnt >= HDR && rx_cnt < rx_end) begin
          rd_data  <= spm_out;
          rd_valid <= 1'b1;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (req) begin
            if (len != '0) begin
              cur.addr  <= addr;
              cur.len   <= len;
              busy      <= 1'b1;
              spm_in    <= CMD;
              spm_empty <= 1'b0;
              tx_cnt    <= '0;
              rx_cnt    <= '0;
              state     <= S_CMD;
            end else begin
              // Zero-length read completes immediately with no SPI traffic.
              done <= 1'b1;
            end
          end
        end

        S_CMD: begin
          if (tx_take) begin
            spm_in   <= cur.addr[23:16];
            addr_idx <= 2'd0;
            state    <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (tx_take) begin
            unique case (addr_idx)
              2'd0: begin
                spm_in   <= cur.addr[15:8];
                addr_idx <= 2'd1;
              end
              2'd1: begin
                spm_in   <= cur.addr[7:0];
                addr_idx <= 2'd2;
              end
              default: begin
                spm_in <= 8'h00;
                tx_cnt <= '0;
                state  <= S_DUMMY;
              end
            endcase
          end
        end

        S_DUMMY: begin
          // Each dummy byte clocks one data byte back from the flash.
          if (tx_take) begin
            tx_cnt <= tx_nxt;
            if (tx_nxt == {1'b0, cur.len}) begin
              spm_empty <= 1'b1;
              state     <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (rx_cnt == rx_end) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          // spm_empty stays high here so the master deasserts cs_n.
          if (gap_cnt == GW'(GAP - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
